ts_serial_rx: RTL and testbench
===============================

# ts_serial_rx

Receiver for the timestamper's `serialout` stream, used on the host-side FPGA and as the self-checking monitor in the system bench. It oversamples the asynchronous 8N1 line and reassembles 7-byte event frames. It checks each frame's sync byte, channel byte and XOR checksum, and presents each good record (channel number plus 32-bit timestamp) on a valid/ready interface. Framing, checksum and overrun faults are reported as one-cycle error pulses.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit (115200 baud at 50 MHz); must be ≥ 4.
- `TIMEOUT_CLKS`, default 8680: maximum idle gap between bytes inside a frame (20 bit times).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serialin`  in  1  asynchronous serial line; idles high.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts the record when `rec_valid && rec_ready`.
- `rec_channel`  out  2  channel number of the record (0–3).
- `rec_timestamp`  out  32  timestamp of the record.
- `err_framing`  out  1  one-cycle pulse on a bad stop bit, a bad channel byte or an intra-frame timeout.
- `err_checksum`  out  1  one-cycle pulse when a frame's checksum mismatches.
- `err_overrun`  out  1  one-cycle pulse when a good frame is dropped because the output is full.

## Operation
- Frame format: 7 bytes, each 8N1 with data LSB-first.
  - B0 = 0xA5 (sync).
  - B1 = {6'b0, ch[1:0]}.
  - B2..B5 = timestamp, MSB byte first.
  - B6 = B1^B2^B3^B4^B5.
- Input conditioning: `serialin` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- Byte receiver states are IDLE, START, DATA, STOP.
  - IDLE→START when the synced line reads 0.
  - START waits CLKS_PER_BIT/2 (integer divide). If the line is then 1, it is a glitch: return to IDLE with no error. If 0, go to DATA.
  - DATA samples 8 bits, one every CLKS_PER_BIT cycles.
  - STOP samples once more after CLKS_PER_BIT. A 1 pulses `byte_valid` for one cycle. A 0 pulses `byte_err`, and the receiver waits for the line to read 1 before returning to IDLE.
- Frame parser states are HUNT, CHAN, TS, CSUM.
  - HUNT: ignore every byte other than 0xA5. On 0xA5 go to CHAN.
  - CHAN: if the upper 6 bits are nonzero, pulse `err_framing` and go to HUNT. Otherwise latch ch and go to TS.
  - TS: a 2-bit counter shifts in 4 bytes, then goes to CSUM.
  - CSUM: on a match, deliver the record. On a mismatch, pulse `err_checksum`. Go to HUNT in both cases.
- Timeout: in CHAN, TS or CSUM, if TIMEOUT_CLKS cycles pass with no `byte_valid`, pulse `err_framing` and go to HUNT. The gap counter restarts on every `byte_valid`.
- A `byte_err` in any parser state pulses `err_framing` and returns the parser to HUNT. This is a single pulse even when the parser was already in HUNT.
- Delivery:
  - The output is a single register. If `!rec_valid || rec_ready` in the cycle a good checksum is seen, the new record loads and `rec_valid` is 1 on the next cycle.
  - Otherwise the new record is discarded, the held record is unchanged, and `err_overrun` pulses.
  - Accept and reload in the same cycle is allowed: the old record is consumed and the new one loaded, with no gap.
- Error pulses are mutually exclusive per frame; each frame fault produces exactly one pulse.
- Reset values:
  - `rec_valid`=0, `rec_channel`=0, `rec_timestamp`=0, all error outputs 0.
  - Byte receiver in IDLE, parser in HUNT, all counters 0.
  - A reset in the middle of a frame drops that frame. The remaining bytes of the frame are then ignored because they do not match 0xA5. Stray 0xA5 bytes inside that residue are a known false-sync risk and are rejected later by the checksum.

## Timing
- Sample point: each bit is sampled at CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after the synced falling edge, for k = 1..9 (k = 9 is the stop bit).
- Synchronizer latency is 2 cycles.
- `byte_valid` pulses in the cycle of the stop-bit sample.
- Record latency: `rec_valid` rises 1 cycle after B6's `byte_valid`. All error pulses occur in the same cycle as the triggering `byte_valid`/`byte_err` or timeout.
- `rec_channel` and `rec_timestamp` are stable while `rec_valid && !rec_ready`.
- Back-to-back bytes with no idle time between them must be received. Tolerated baud mismatch is ±3%.

## Structure
- Package `ts_pkg`, shared with the transmitter:
  - `TS_SYNC_BYTE` = 8'hA5
  - `TS_FRAME_BYTES` = 7
  - `TS_TS_BYTES` = 4
  - `TS_CH_W` = 2
  - `TS_W` = 32
  - the parser state enum
- Sub-module `ts_uart_rx_byte`: contains the synchronizer and the bit FSM. Its outputs are `byte_data[7:0]`, `byte_valid` and `byte_err`.
- The top level holds the parser, the timeout counter and the output register.

## Test plan
All scenarios use CLKS_PER_BIT=8 and TIMEOUT_CLKS=160.
- Send A5 02 12 34 56 78 (B6 = 02^12^34^56^78 = 0x0A), with `rec_ready`=1 → one `rec_valid` pulse with ch=2 and ts=0x12345678. The pulse occurs 1 cycle after the last stop-bit sample. No errors.
- Send the same frame with B6=0x0B → `err_checksum` pulses once and `rec_valid` stays 0.
- Hold `rec_ready`=0 and send two good frames (ch 1 with ts 0x00000001, then ch 3 with ts 0xFFFFFFFF) → the first record is held, `err_overrun` pulses once, and raising `rec_ready` yields ch=1, ts=1.
- Send garbage 00 FF, then A5 05 … → `err_framing` on the channel byte. Follow with a good frame → that frame is received correctly.
- Send A5 01 AA, then idle for 200 cycles → `err_framing` pulses at 160 cycles after the last `byte_valid`. A following good frame is received.
- A 3-cycle low glitch on an idle line → no byte and no error. A stop bit forced to 0 → `err_framing` pulses. Asserting `rst` in mid-frame → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared constants and types for the timestamper serial link (transmitter and receiver).
// Frame: sync, channel, 4 timestamp bytes MSB first, XOR checksum of bytes 1..5.
package ts_pkg;
   localparam logic [7:0] TS_SYNC_BYTE   = 8'hA5;
   localparam int         TS_FRAME_BYTES = 7;
   localparam int         TS_TS_BYTES    = 4;
   localparam int         TS_CH_W        = 2;
   localparam int         TS_W           = 32;

   typedef enum logic [1:0] {P_HUNT, P_CHAN, P_TS, P_CSUM} parse_state_e;
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;

   typedef struct packed {
      logic [TS_CH_W-1:0] ch;
      logic [TS_W-1:0]    ts;
   } rec_t;
endpackage

// File: rtl/ts_serial_rx_if.sv
// Record handshake between the frame receiver and its consumer; a record moves on valid && ready.
// The master holds channel/timestamp stable while valid is high and ready is low.
interface ts_serial_rx_if;
   import ts_pkg::*;

   logic               rec_valid;
   logic               rec_ready;
   logic [TS_CH_W-1:0] rec_channel;
   logic [TS_W-1:0]    rec_timestamp;

   modport master (output rec_valid, output rec_channel, output rec_timestamp, input rec_ready);
   modport slave  (input rec_valid, input rec_channel, input rec_timestamp, output rec_ready);
endinterface

// File: rtl/ts_uart_rx_byte.sv
// 8N1 byte receiver with 2-flop input sync; byte_valid/byte_err pulse in the stop-bit sample cycle,
// which lands CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the synced falling edge. No backpressure.
module ts_uart_rx_byte
   import ts_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serialin,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_err
);
   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             sync1_q, sync2_q;
   byte_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             brk_q, brk_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= B_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         brk_q   <= 1'b0;
      end else begin
         sync1_q <= serialin;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         brk_q   <= brk_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      brk_d      = brk_q;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
      unique case (state_q)
         B_IDLE: begin
            cnt_d = '0;
            if (!sync2_q) state_d = B_START;
         end
         B_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync2_q ? B_IDLE : B_DATA;
            end
         end
         B_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = B_STOP;
            end
         end
         B_STOP: begin
            // After a bad stop bit, park here until the line returns to idle.
            if (brk_q) begin
               cnt_d = '0;
               if (sync2_q) begin
                  brk_d   = 1'b0;
                  state_d = B_IDLE;
               end
            end else if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (sync2_q) begin
                  byte_valid = 1'b1;
                  state_d    = B_IDLE;
               end else begin
                  byte_err = 1'b1;
                  brk_d    = 1'b1;
               end
            end
         end
         default: state_d = B_IDLE;
      endcase
   end

   assign byte_data = shift_q;
endmodule

// File: rtl/ts_serial_rx.sv
// Timestamper frame receiver: validates 7-byte frames, emits {channel, timestamp} records.
// Record valid 1 cycle after the checksum byte; a full output register drops the frame and pulses err_overrun.
module ts_serial_rx
   import ts_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 8680
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          serialin,
   ts_serial_rx_if.master rec,
   output logic          err_framing,
   output logic          err_checksum,
   output logic          err_overrun
);
   localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

   logic [7:0]   byte_data;
   logic         byte_valid, byte_err;
   parse_state_e pstate_q, pstate_d;
   logic [1:0]   ts_idx_q, ts_idx_d;
   logic [7:0]   csum_q, csum_d;
   rec_t         acc_q, acc_d;
   rec_t         rec_q, rec_d;
   logic         rec_vld_q, rec_vld_d;
   logic [TO_W-1:0] gap_q, gap_d;
   logic         timeout;

   ts_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk        (clk),
      .rst        (rst),
      .serialin   (serialin),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q  <= P_HUNT;
         ts_idx_q  <= '0;
         csum_q    <= '0;
         acc_q     <= '0;
         rec_q     <= '0;
         rec_vld_q <= 1'b0;
         gap_q     <= '0;
      end else begin
         pstate_q  <= pstate_d;
         ts_idx_q  <= ts_idx_d;
         csum_q    <= csum_d;
         acc_q     <= acc_d;
         rec_q     <= rec_d;
         rec_vld_q <= rec_vld_d;
         gap_q     <= gap_d;
      end
   end

   // gap_q counts cycles since the last byte_valid, so it reaches TIMEOUT_CLKS exactly that many cycles later.
   assign timeout = (pstate_q != P_HUNT) && (gap_q == TO_W'(TIMEOUT_CLKS));

   always_comb begin
      pstate_d     = pstate_q;
      ts_idx_d     = ts_idx_q;
      csum_d       = csum_q;
      acc_d        = acc_q;
      rec_d        = rec_q;
      rec_vld_d    = rec_vld_q && !rec.rec_ready;
      gap_d        = (pstate_q == P_HUNT) ? '0 : gap_q + TO_W'(1);
      err_framing  = 1'b0;
      err_checksum = 1'b0;
      err_overrun  = 1'b0;
      if (byte_err) begin
         err_framing = 1'b1;
         pstate_d    = P_HUNT;
         gap_d       = '0;
      end else if (byte_valid) begin
         gap_d = TO_W'(1);
         unique case (pstate_q)
            P_HUNT: if (byte_data == TS_SYNC_BYTE) pstate_d = P_CHAN;
            P_CHAN: begin
               if (byte_data[7:TS_CH_W] != '0) begin
                  err_framing = 1'b1;
                  pstate_d    = P_HUNT;
               end else begin
                  acc_d.ch = byte_data[TS_CH_W-1:0];
                  csum_d   = byte_data;
                  ts_idx_d = '0;
                  pstate_d = P_TS;
               end
            end
            P_TS: begin
               acc_d.ts = {acc_q.ts[TS_W-9:0], byte_data};
               csum_d   = csum_q ^ byte_data;
               ts_idx_d = ts_idx_q + 2'd1;
               if (ts_idx_q == 2'(TS_TS_BYTES - 1)) pstate_d = P_CSUM;
            end
            P_CSUM: begin
               pstate_d = P_HUNT;
               if (byte_data != csum_q) begin
                  err_checksum = 1'b1;
               end else if (!rec_vld_q || rec.rec_ready) begin
                  rec_d     = acc_q;
                  rec_vld_d = 1'b1;
               end else begin
                  err_overrun = 1'b1;
               end
            end
            default: pstate_d = P_HUNT;
         endcase
      end else if (timeout) begin
         err_framing = 1'b1;
         pstate_d    = P_HUNT;
         gap_d       = '0;
      end
   end

   assign rec.rec_valid     = rec_vld_q;
   assign rec.rec_channel   = rec_q.ch;
   assign rec.rec_timestamp = rec_q.ts;
endmodule

// File: tb/tb_ts_serial_rx.sv
// Bench for ts_serial_rx: vector table, hand-written corner sequences, and randomized frames
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_ts_serial_rx;
   import ts_pkg::*;

   localparam int CPB    = 8;
   localparam int TMO    = 160;
   localparam int BV_LAT = 2 + CPB / 2 + 9 * CPB;  // start-bit drive to stop-bit sample

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serialin = 1'b1;
   logic err_framing, err_checksum, err_overrun;

   ts_serial_rx_if rec_if ();

   ts_serial_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .serialin     (serialin),
      .rec          (rec_if),
      .err_framing  (err_framing),
      .err_checksum (err_checksum),
      .err_overrun  (err_overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int n_fr = 0, n_cs = 0, n_ov = 0, stab_bad = 0;
   int rise_cyc = -1, fr_cyc = -1;
   int last_start = 0;
   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];
   logic        prev_vld = 1'b0, prev_rdy = 1'b0;
   logic [33:0] prev_rec = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (rec_if.rec_valid && rec_if.rec_ready)
            got_q.push_back({rec_if.rec_channel, rec_if.rec_timestamp});
         if (rec_if.rec_valid && !prev_vld) rise_cyc = cyc;
         if (prev_vld && !prev_rdy &&
             (!rec_if.rec_valid || {rec_if.rec_channel, rec_if.rec_timestamp} != prev_rec))
            stab_bad++;
         if (err_framing) begin
            n_fr++;
            fr_cyc = cyc;
         end
         if (err_checksum) n_cs++;
         if (err_overrun) n_ov++;
      end
      prev_vld = rec_if.rec_valid && !rst;
      prev_rdy = rec_if.rec_ready;
      prev_rec = {rec_if.rec_channel, rec_if.rec_timestamp};
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      last_start = cyc;
      serialin = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         serialin = b[i];
         tick(CPB);
      end
      serialin = stop_bit;
      tick(CPB);
      serialin = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] chb, input logic [31:0] ts, input logic [7:0] b6, input int gap);
      send_byte(TS_SYNC_BYTE);
      tick(gap);
      send_byte(chb);
      tick(gap);
      for (int i = 3; i >= 0; i--) begin
         send_byte(ts[i*8 +: 8]);
         tick(gap);
      end
      send_byte(b6);
   endtask

   function automatic logic [7:0] csum_of(input logic [7:0] chb, input logic [31:0] ts);
      return chb ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
   endfunction

   function automatic longint err_sum();
      return longint'(err_framing) + longint'(err_checksum) + longint'(err_overrun);
   endfunction

   typedef struct {
      logic [7:0]  chb;
      logic [31:0] ts;
      logic [7:0]  b6;
      bit          ok;
      bit          fr;
      bit          cs;
   } vec_t;

   vec_t vecs[9];
   int fr0, cs0, ov0, exp_fr, exp_cs, v_last, typ, ng, gap;
   logic [7:0]  gb, chb;
   logic [1:0]  ch;
   logic [31:0] ts;

   initial begin
      vecs[0] = '{8'h02, 32'h12345678, 8'h0A, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h02, 32'h12345678, 8'h0B, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h01, 32'h00000001, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h03, 32'hFFFFFFFF, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h05, 32'h00000000, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 32'hA5A5A5A5, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h02, 32'h00000000, 8'h82, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 32'h00000000, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{8'h01, 32'hDEADBEEF, 8'h23, 1'b1, 1'b0, 1'b0};

      rec_if.rec_ready = 1'b1;
      tick(5);
      check("reset rec_valid", longint'(rec_if.rec_valid), 0);
      check("reset rec_channel", longint'(rec_if.rec_channel), 0);
      check("reset rec_timestamp", longint'(rec_if.rec_timestamp), 0);
      check("reset errors", err_sum(), 0);
      rst = 1'b0;
      tick(10);
      check("idle after reset", longint'(rec_if.rec_valid) + err_sum(), 0);

      for (int v = 0; v < 9; v++) begin
         fr0 = n_fr;
         cs0 = n_cs;
         got_q.delete();
         if (vecs[v].chb[7:2] != 6'd0) begin
            send_byte(TS_SYNC_BYTE);
            send_byte(vecs[v].chb);
         end else begin
            send_frame(vecs[v].chb, vecs[v].ts, vecs[v].b6, 0);
         end
         tick(20);
         check($sformatf("vec%0d records", v), got_q.size(), vecs[v].ok ? 1 : 0);
         check($sformatf("vec%0d err_framing", v), n_fr - fr0, vecs[v].fr ? 1 : 0);
         check($sformatf("vec%0d err_checksum", v), n_cs - cs0, vecs[v].cs ? 1 : 0);
         if (vecs[v].ok && got_q.size() == 1) begin
            check($sformatf("vec%0d record", v), longint'(got_q[0]), longint'({vecs[v].chb[1:0], vecs[v].ts}));
            check($sformatf("vec%0d latency", v), rise_cyc, last_start + BV_LAT + 1);
         end
      end

      // Overrun: output held, second good frame dropped.
      rec_if.rec_ready = 1'b0;
      got_q.delete();
      ov0 = n_ov;
      stab_bad = 0;
      send_frame(8'h01, 32'h00000001, 8'h00, 0);
      send_frame(8'h03, 32'hFFFFFFFF, 8'h03, 0);
      tick(20);
      check("overrun pulses", n_ov - ov0, 1);
      check("overrun held valid", longint'(rec_if.rec_valid), 1);
      check("overrun held record", longint'({rec_if.rec_channel, rec_if.rec_timestamp}), longint'({2'd1, 32'h1}));
      rec_if.rec_ready = 1'b1;
      tick(3);
      check("overrun drained count", got_q.size(), 1);
      if (got_q.size() == 1) check("overrun drained record", longint'(got_q[0]), longint'({2'd1, 32'h1}));
      check("overrun valid cleared", longint'(rec_if.rec_valid), 0);
      check("held record stable", stab_bad, 0);

      // Garbage then bad channel, then a good frame.
      fr0 = n_fr;
      got_q.delete();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(TS_SYNC_BYTE);
      send_byte(8'h05);
      tick(20);
      check("garbage bad chan framing", n_fr - fr0, 1);
      send_frame(8'h02, 32'h12345678, 8'h0A, 0);
      tick(20);
      check("after garbage record", got_q.size() == 1 ? longint'(got_q[0]) : -1, longint'({2'd2, 32'h12345678}));

      // Intra-frame timeout.
      fr0 = n_fr;
      got_q.delete();
      send_byte(TS_SYNC_BYTE);
      send_byte(8'h01);
      send_byte(8'hAA);
      v_last = last_start + BV_LAT;
      tick(200);
      check("timeout framing", n_fr - fr0, 1);
      check("timeout cycle", fr_cyc, v_last + TMO);
      send_frame(8'h02, 32'h12345678, 8'h0A, 0);
      tick(20);
      check("after timeout record", got_q.size() == 1 ? longint'(got_q[0]) : -1, longint'({2'd2, 32'h12345678}));

      // Short low glitch on an idle line.
      fr0 = n_fr; cs0 = n_cs; ov0 = n_ov;
      got_q.delete();
      serialin = 1'b0;
      tick(3);
      serialin = 1'b1;
      tick(100);
      check("glitch errors", (n_fr - fr0) + (n_cs - cs0) + (n_ov - ov0), 0);
      check("glitch records", got_q.size(), 0);
      send_frame(8'h03, 32'h0BADF00D, 8'h58, 0);
      tick(20);
      check("after glitch record", got_q.size() == 1 ? longint'(got_q[0]) : -1, longint'({2'd3, 32'h0BADF00D}));

      // Bad stop bit.
      fr0 = n_fr;
      send_byte(TS_SYNC_BYTE, 1'b0);
      tick(20);
      check("bad stop framing", n_fr - fr0, 1);

      // Reset in mid-frame with a record held.
      rec_if.rec_ready = 1'b0;
      send_frame(8'h02, 32'h12345678, 8'h0A, 0);
      tick(5);
      check("pre-reset valid", longint'(rec_if.rec_valid), 1);
      send_byte(TS_SYNC_BYTE);
      send_byte(8'h02);
      serialin = 1'b0;
      tick(20);
      rst = 1'b1;
      tick(1);
      check("mid-frame reset valid", longint'(rec_if.rec_valid), 0);
      check("mid-frame reset record", longint'({rec_if.rec_channel, rec_if.rec_timestamp}), 0);
      check("mid-frame reset errors", err_sum(), 0);
      serialin = 1'b1;
      tick(3);
      rst = 1'b0;
      rec_if.rec_ready = 1'b1;
      tick(5);
      fr0 = n_fr; cs0 = n_cs;
      got_q.delete();
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h78);
      send_byte(8'h0A);
      tick(20);
      check("residue ignored", longint'(got_q.size()) + (n_fr - fr0) + (n_cs - cs0), 0);
      send_frame(8'h01, 32'hDEADBEEF, 8'h23, 0);
      tick(20);
      check("after reset record", got_q.size() == 1 ? longint'(got_q[0]) : -1, longint'({2'd1, 32'hDEADBEEF}));

      // Randomized frames against the frame-level model.
      got_q.delete();
      exp_q.delete();
      fr0 = n_fr; cs0 = n_cs; ov0 = n_ov;
      exp_fr = 0;
      exp_cs = 0;
      for (int f = 0; f < 30; f++) begin
         typ = int'($urandom_range(0, 2));
         ng  = int'($urandom_range(0, 2));
         for (int g = 0; g < ng; g++) begin
            gb = 8'($urandom_range(0, 255));
            if (gb == TS_SYNC_BYTE) gb = 8'h5A;
            send_byte(gb);
            tick(int'($urandom_range(0, 40)));
         end
         ch  = 2'($urandom_range(0, 3));
         ts  = $urandom();
         gap = int'($urandom_range(0, 40));
         chb = {6'd0, ch};
         case (typ)
            0: begin
               send_frame(chb, ts, csum_of(chb, ts), gap);
               exp_q.push_back({ch, ts});
            end
            1: begin
               send_frame(chb, ts, csum_of(chb, ts) ^ 8'($urandom_range(1, 255)), gap);
               exp_cs++;
            end
            default: begin
               chb = {6'($urandom_range(1, 63)), ch};
               send_byte(TS_SYNC_BYTE);
               tick(gap);
               send_byte(chb);
               exp_fr++;
            end
         endcase
         tick(int'($urandom_range(0, 40)));
      end
      tick(20);
      check("random record count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("random record %0d", i), longint'(got_q[i]), longint'(exp_q[i]));
      check("random err_framing", n_fr - fr0, exp_fr);
      check("random err_checksum", n_cs - cs0, exp_cs);
      check("random err_overrun", n_ov - ov0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
